// File: rtl/dht11_responder.sv
// DHT11 sensor emulator on an open-drain single-wire line: detects the host start
// pulse, then answers with the response preamble and a 40-bit frame, MSB first.
module dht11_responder #(
  parameter int T_START_MIN = 900000,
  parameter int T_WAIT      = 1500,
  parameter int T_RESP_LOW  = 4000,
  parameter int T_RESP_HIGH = 4000,
  parameter int T_BIT_LOW   = 2500,
  parameter int T_BIT0_HIGH = 1300,
  parameter int T_BIT1_HIGH = 3500,
  parameter int T_END_LOW   = 2500,
  parameter int T_GLITCH    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [7:0] hum_int,
  input  logic [7:0] hum_dec,
  input  logic [7:0] temp_int,
  input  logic [7:0] temp_dec,
  inout  wire        data,
  output logic       busy,
  output logic       frame_done,
  output logic       err
);

  typedef enum logic [2:0] {
    IDLE, HOST_LOW, WAIT, RESP_LOW, RESP_HIGH, BIT_LOW, BIT_HIGH, END_LOW
  } state_t;

  state_t      state, state_nx;
  logic [31:0] cnt, cnt_nx;
  logic [5:0]  bit_idx, bit_idx_nx;
  logic [1:0]  age, age_nx;
  logic [7:0]  glitch, glitch_nx;
  logic [39:0] word;
  logic        sync1, sync2, d_s;
  logic        armed, drv_low, latch, contend, done_nx, err_nx;

  function automatic logic [7:0] checksum(input logic [7:0] a, input logic [7:0] b,
                                          input logic [7:0] c, input logic [7:0] d);
    return a + b + c + d;
  endfunction

  function automatic logic [31:0] high_len(input logic b);
    return b ? 32'(T_BIT1_HIGH - 1) : 32'(T_BIT0_HIGH - 1);
  endfunction

  assign d_s  = sync2;
  assign data = drv_low ? 1'b0 : 1'bz;

  // Released phases: after the settle window, a run of low samples means someone else drives
  assign contend = (state == RESP_HIGH || state == BIT_HIGH) && (age == 2'd3) && !d_s &&
                   (glitch == 8'(T_GLITCH - 1));

  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    bit_idx_nx = bit_idx;
    age_nx     = age;
    glitch_nx  = glitch;
    latch      = 1'b0;
    done_nx    = 1'b0;
    err_nx     = 1'b0;
    if (state == RESP_HIGH || state == BIT_HIGH) begin
      if (age != 2'd3)  age_nx    = age + 2'd1;
      else if (!d_s)    glitch_nx = glitch + 8'd1;
      else              glitch_nx = 8'd0;
    end
    case (state)
      IDLE: begin
        if (en && armed && !d_s) begin
          state_nx = HOST_LOW;
          cnt_nx   = 32'd1;
        end
      end
      HOST_LOW: begin
        if (!en) begin
          state_nx = IDLE;
        end else if (!d_s) begin
          if (cnt < 32'(T_START_MIN)) cnt_nx = cnt + 32'd1;
        end else if (cnt >= 32'(T_START_MIN)) begin
          latch    = 1'b1;
          state_nx = WAIT;
          cnt_nx   = 32'(T_WAIT - 1);
        end else begin
          state_nx = IDLE;
        end
      end
      WAIT: begin
        if (cnt == 32'd0) begin
          state_nx = RESP_LOW;
          cnt_nx   = 32'(T_RESP_LOW - 1);
        end else cnt_nx = cnt - 32'd1;
      end
      RESP_LOW: begin
        if (cnt == 32'd0) begin
          state_nx  = RESP_HIGH;
          cnt_nx    = 32'(T_RESP_HIGH - 1);
          age_nx    = 2'd0;
          glitch_nx = 8'd0;
        end else cnt_nx = cnt - 32'd1;
      end
      RESP_HIGH: begin
        if (contend) begin
          state_nx = IDLE;
          err_nx   = 1'b1;
        end else if (cnt == 32'd0) begin
          state_nx   = BIT_LOW;
          bit_idx_nx = 6'd39;
          cnt_nx     = 32'(T_BIT_LOW - 1);
        end else cnt_nx = cnt - 32'd1;
      end
      BIT_LOW: begin
        if (cnt == 32'd0) begin
          state_nx  = BIT_HIGH;
          cnt_nx    = high_len(word[bit_idx]);
          age_nx    = 2'd0;
          glitch_nx = 8'd0;
        end else cnt_nx = cnt - 32'd1;
      end
      BIT_HIGH: begin
        if (contend) begin
          state_nx = IDLE;
          err_nx   = 1'b1;
        end else if (cnt == 32'd0) begin
          if (bit_idx != 6'd0) begin
            bit_idx_nx = bit_idx - 6'd1;
            state_nx   = BIT_LOW;
            cnt_nx     = 32'(T_BIT_LOW - 1);
          end else begin
            state_nx = END_LOW;
            cnt_nx   = 32'(T_END_LOW - 1);
          end
        end else cnt_nx = cnt - 32'd1;
      end
      END_LOW: begin
        if (cnt == 32'd0) begin
          state_nx = IDLE;
          done_nx  = 1'b1;
        end else cnt_nx = cnt - 32'd1;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= 32'd0;
      bit_idx    <= 6'd0;
      age        <= 2'd0;
      glitch     <= 8'd0;
      drv_low    <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      err        <= 1'b0;
      armed      <= 1'b0;
      sync1      <= 1'b1;
      sync2      <= 1'b1;
    end else begin
      sync1      <= data;
      sync2      <= sync1;
      state      <= state_nx;
      cnt        <= cnt_nx;
      bit_idx    <= bit_idx_nx;
      age        <= age_nx;
      glitch     <= glitch_nx;
      drv_low    <= (state_nx == RESP_LOW) || (state_nx == BIT_LOW) || (state_nx == END_LOW);
      busy       <= !((state_nx == IDLE) || (state_nx == HOST_LOW));
      frame_done <= done_nx;
      err        <= err_nx;
      // A fresh request needs the line seen high in IDLE first
      armed      <= (state == IDLE) && (armed || d_s);
    end
  end

  always_ff @(posedge clk) begin
    if (latch) word <= {hum_int, hum_dec, temp_int, temp_dec,
                        checksum(hum_int, hum_dec, temp_int, temp_dec)};
  end

endmodule

// File: tb/tb_dht11_responder.sv
// Bench for dht11_responder: a host model drives start pulses on a pulled-up line and a
// line monitor records low/high run lengths, which are decoded back into the frame.
module tb_dht11_responder;

  localparam int TSM = 200, TW = 15, TRL = 40, TRH = 40, TBL = 25;
  localparam int TB0 = 13, TB1 = 35, TEL = 25, TGL = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b1;
  logic [7:0] hum_int = 8'h00, hum_dec = 8'h00, temp_int = 8'h00, temp_dec = 8'h00;
  logic busy, frame_done, err;
  logic host_low = 1'b0;
  wire  line;

  pullup (line);
  assign line = host_low ? 1'b0 : 1'bz;

  dht11_responder #(
    .T_START_MIN(TSM), .T_WAIT(TW), .T_RESP_LOW(TRL), .T_RESP_HIGH(TRH), .T_BIT_LOW(TBL),
    .T_BIT0_HIGH(TB0), .T_BIT1_HIGH(TB1), .T_END_LOW(TEL), .T_GLITCH(TGL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .hum_int(hum_int), .hum_dec(hum_dec),
    .temp_int(temp_int), .temp_dec(temp_dec), .data(line), .busy(busy),
    .frame_done(frame_done), .err(err)
  );

  always #10 clk = ~clk;

  typedef struct { bit lvl; int len; } seg_t;
  typedef struct {
    int         low_cyc;
    bit         en;
    logic [7:0] hi, hd, ti, td, ck;
    bit         resp;
  } vec_t;

  seg_t seg_q[$];
  seg_t tmp_seg;
  bit   mon_on = 1'b0, cur_lvl = 1'b1, busy_seen, fd_busy_ok, prev_busy;
  int   run, fd_cnt, err_cnt;
  int   n_pass = 0, n_total = 0;

  always @(negedge clk) begin
    if (mon_on) begin
      if (((line === 1'b0) ? 1'b0 : 1'b1) == cur_lvl) run++;
      else begin
        tmp_seg.lvl = cur_lvl;
        tmp_seg.len = run;
        seg_q.push_back(tmp_seg);
        cur_lvl = ~cur_lvl;
        run = 1;
      end
      if (frame_done === 1'b1) begin
        fd_cnt++;
        if (busy === 1'b0 && prev_busy) fd_busy_ok = 1'b1;
      end
      if (err === 1'b1) err_cnt++;
      if (busy === 1'b1) busy_seen = 1'b1;
      prev_busy = (busy === 1'b1);
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  task automatic mon_clear();
    seg_q.delete();
    cur_lvl = 1'b1; run = 0; fd_cnt = 0; err_cnt = 0;
    busy_seen = 1'b0; fd_busy_ok = 1'b0; prev_busy = 1'b0;
    mon_on = 1'b1;
  endtask

  // Host start pulse of n cycles; the monitor restarts at the release.
  task automatic host_pulse(input int n);
    @(posedge clk); #1 host_low = 1'b1;
    repeat (n) @(posedge clk);
    #1 host_low = 1'b0;
    mon_clear();
  endtask

  task automatic wait_segs(input string name, input int n);
    for (int i = 0; i < 5000; i++) begin
      if (seg_q.size() >= n) break;
      @(posedge clk);
    end
    check(name, int'(seg_q.size() >= n), 1);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk);
      if (fd_cnt != 0 || err_cnt != 0) break;
    end
    repeat (4) @(posedge clk);
  endtask

  task automatic decode_check(input string tag, input vec_t v);
    logic [39:0] w;
    int bad_low, bad_width;
    w = '0; bad_low = 0; bad_width = 0;
    check({tag, "_frame_done_once"}, fd_cnt, 1);
    check({tag, "_busy_falls_with_done"}, int'(fd_busy_ok), 1);
    check({tag, "_no_err"}, err_cnt, 0);
    check({tag, "_segments"}, seg_q.size(), 84);
    if (seg_q.size() == 84) begin
      check({tag, "_wait_high"}, seg_q[0].len, TW + 3);
      check({tag, "_resp_low"}, seg_q[1].len, TRL);
      check({tag, "_resp_high"}, seg_q[2].len, TRH);
      for (int b = 0; b < 40; b++) begin
        if (seg_q[3 + 2*b].len != TBL) bad_low++;
        if (seg_q[4 + 2*b].len == TB1) w = {w[38:0], 1'b1};
        else begin
          w = {w[38:0], 1'b0};
          if (seg_q[4 + 2*b].len != TB0) bad_width++;
        end
      end
      check({tag, "_bit_low_widths"}, bad_low, 0);
      check({tag, "_bit_high_widths"}, bad_width, 0);
      check({tag, "_end_low"}, seg_q[83].len, TEL);
      check({tag, "_hum_int"}, int'(w[39:32]), int'(v.hi));
      check({tag, "_hum_dec"}, int'(w[31:24]), int'(v.hd));
      check({tag, "_temp_int"}, int'(w[23:16]), int'(v.ti));
      check({tag, "_temp_dec"}, int'(w[15:8]), int'(v.td));
      check({tag, "_checksum"}, int'(w[7:0]), int'(v.ck));
    end
  endtask

  // mode 1: change temp_int while bit 10 is on the line
  task automatic do_frame(input string tag, input vec_t v, input int mode);
    hum_int = v.hi; hum_dec = v.hd; temp_int = v.ti; temp_dec = v.td;
    en = v.en;
    repeat (20) @(posedge clk);
    host_pulse(v.low_cyc);
    if (v.resp) begin
      if (mode == 1) begin
        wait_segs({tag, "_bit10_reached"}, 23);
        temp_int = 8'h55;
      end
      wait_done();
      decode_check(tag, v);
    end else begin
      repeat (300) @(posedge clk);
      check({tag, "_no_drive"}, seg_q.size(), 0);
      check({tag, "_busy_stays_low"}, int'(busy_seen), 0);
    end
    en = 1'b1;
  endtask

  vec_t tbl[6];
  vec_t std_v;

  initial begin
    tbl[0] = '{150,     1'b1, 8'h37, 8'h00, 8'h19, 8'h00, 8'h50, 1'b0};
    tbl[1] = '{TSM - 1, 1'b1, 8'h37, 8'h00, 8'h19, 8'h00, 8'h50, 1'b0};
    tbl[2] = '{250,     1'b1, 8'h37, 8'h00, 8'h19, 8'h00, 8'h50, 1'b1};
    tbl[3] = '{TSM,     1'b1, 8'hFF, 8'hFF, 8'h80, 8'h02, 8'h80, 1'b1};
    tbl[4] = '{300,     1'b0, 8'h37, 8'h00, 8'h19, 8'h00, 8'h50, 1'b0};
    tbl[5] = '{300,     1'b1, 8'hA5, 8'h5A, 8'h01, 8'hFE, 8'hFE, 1'b1};
    std_v  = tbl[2];

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_busy", int'(busy), 0);
    check("reset_frame_done", int'(frame_done), 0);
    check("reset_err", int'(err), 0);
    check("reset_line_released", int'(line === 1'b1), 1);
    @(posedge clk); #1 rst_n = 1'b1;

    for (int i = 0; i < 6; i++) do_frame($sformatf("vec%0d", i), tbl[i], 0);

    // en dropped while the host holds the line low
    repeat (20) @(posedge clk);
    @(posedge clk); #1 host_low = 1'b1;
    repeat (50) @(posedge clk);
    #1 en = 1'b0;
    repeat (10) @(posedge clk);
    #1 en = 1'b1;
    repeat (190) @(posedge clk);
    #1 host_low = 1'b0;
    mon_clear();
    repeat (300) @(posedge clk);
    check("en_drop_no_drive", seg_q.size(), 0);
    check("en_drop_no_busy", int'(busy_seen), 0);

    // Inputs changed mid-frame do not reach the frame in flight
    do_frame("midchg", std_v, 1);
    temp_int = 8'h19;

    // Contention inside the bit-5 released phase (0x37 bit 5 is a long one)
    repeat (20) @(posedge clk);
    host_pulse(250);
    wait_segs("cont_bit5_reached", 14);
    repeat (5) @(posedge clk);
    #1 host_low = 1'b1;
    repeat (10) @(posedge clk);
    #1 host_low = 1'b0;
    repeat (2) @(posedge clk);
    begin
      int n_after;
      n_after = seg_q.size();
      repeat (3000) @(posedge clk);
      check("cont_err_pulse", err_cnt, 1);
      check("cont_no_frame_done", fd_cnt, 0);
      check("cont_busy_low", int'(busy), 0);
      check("cont_line_released", seg_q.size(), n_after);
    end

    // Reset during the response low phase
    repeat (20) @(posedge clk);
    host_pulse(250);
    wait_segs("rst_resp_low_reached", 1);
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rst_mid_line_released", int'(line === 1'b1), 1);
    check("rst_mid_busy", int'(busy), 0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (200) @(posedge clk);
    check("rst_mid_no_err", err_cnt, 0);
    check("rst_mid_no_done", fd_cnt, 0);
    do_frame("after_rst", std_v, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/dht11_responder.md
Name: dht11_responder

Overview:
- Emulates a DHT11 sensor on the single-wire, open-drain data line.
- Answers a host start pulse with the standard response preamble, then 40 data bits (humidity int/dec, temperature int/dec, checksum), MSB first.
- Serves as a bench/loopback partner for the DHT11 host reader and as a stand-in sensor on boards without one fitted.
- Clocked at 50 MHz; all timing parameters are in clock cycles.

Parameters:
- T_START_MIN, 900000, minimum host low time accepted as a start request (18 ms)
- T_WAIT, 1500, released time after the host releases, before the response begins (30 us)
- T_RESP_LOW, 4000, response low time (80 us)
- T_RESP_HIGH, 4000, response high/released time (80 us)
- T_BIT_LOW, 2500, low time preceding each bit (50 us)
- T_BIT0_HIGH, 1300, released time encoding a 0 (26 us)
- T_BIT1_HIGH, 3500, released time encoding a 1 (70 us)
- T_END_LOW, 2500, trailing low time after bit 39 (50 us)
- T_GLITCH, 4, consecutive low samples during a released phase that count as contention

Ports:
- clk  in  1  system clock, 50 MHz
- rst_n  in  1  synchronous reset, active-low
- en  in  1  1 = respond to start requests; 0 = ignore new requests
- hum_int  in  8  humidity integer byte
- hum_dec  in  8  humidity decimal byte
- temp_int  in  8  temperature integer byte
- temp_dec  in  8  temperature decimal byte
- data  inout  1  open-drain line: driven 0 or high-Z, never driven 1; external pull-up
- busy  out  1  high from start acceptance until return to IDLE
- frame_done  out  1  one-cycle pulse when END_LOW completes normally
- err  out  1  one-cycle pulse on contention abort

Behaviour:
- Line is sampled through a 2-FF synchronizer (d_s). All decisions use d_s; a 2-cycle latency is inherent.
- data = drv_low ? 1'b0 : 1'bz. drv_low is registered.
- Reset (rst_n=0 at a clk edge): state=IDLE, drv_low=0 (line released on that edge), busy=0, frame_done=0, err=0, counters=0. Reset mid-frame aborts silently; no err pulse.
- Checksum = (hum_int + hum_dec + temp_int + temp_dec) mod 256.
- Frame word = {hum_int, hum_dec, temp_int, temp_dec, checksum}. The word is latched on the IDLE/HOST_LOW->WAIT transition; later input changes do not affect the frame in flight.
- Each timed state loads its counter on entry and leaves after exactly T_x cycles, so T_x counts cycles spent in the state.
- IDLE: drv_low=0, busy=0. If en=1 and d_s=0, go to HOST_LOW with the low counter set to 1.
- HOST_LOW: the low counter increments while d_s=0 and saturates at T_START_MIN.
  - d_s=1 with count>=T_START_MIN: latch the frame, set busy=1, go to WAIT.
  - d_s=1 with count<T_START_MIN: short pulse; return to IDLE with no output.
- WAIT: released for T_WAIT cycles, then go to RESP_LOW.
- RESP_LOW: drv_low=1 for T_RESP_LOW cycles, then go to RESP_HIGH.
- RESP_HIGH: released for T_RESP_HIGH cycles, then go to BIT_LOW with bit_idx=39.
- BIT_LOW: drv_low=1 for T_BIT_LOW cycles, then go to BIT_HIGH.
- BIT_HIGH: released for T_BIT1_HIGH if word[bit_idx]=1, otherwise T_BIT0_HIGH.
  - bit_idx>0: decrement bit_idx, go to BIT_LOW.
  - bit_idx=0: go to END_LOW.
- END_LOW: drv_low=1 for T_END_LOW cycles, then release, pulse frame_done, go to IDLE. busy falls in the same cycle.
- Contention check in RESP_HIGH and BIT_HIGH:
  - The first 3 cycles after entry are ignored (synchronizer plus pull-up rise).
  - After that, T_GLITCH consecutive d_s=0 samples cause: drv_low=0, err pulse, go to IDLE.
- A new request is recognised only from IDLE. After a frame, the line must be seen high in IDLE before a fresh low starts HOST_LOW.
- en=0 mid-frame has no effect; the frame completes. en=0 during HOST_LOW returns to IDLE immediately.
- Frame length from WAIT entry to frame_done is T_WAIT+T_RESP_LOW+T_RESP_HIGH+40*T_BIT_LOW+n1*T_BIT1_HIGH+(40-n1)*T_BIT0_HIGH+T_END_LOW cycles, where n1 = number of ones in the word.

Test Plan:
- Start decode: rst_n low 2 cycles, en=1, inputs 0x37/0x00/0x19/0x00; host drives low 1,050,000 cycles then releases.
  - Required: line released 1500 cycles, then low 4000, high 4000.
  - Decoded bits from high widths: 0x37,0x00,0x19,0x00,0x50.
  - frame_done pulses once; busy falls with it.
- Short pulse: host low 800,000 cycles, then release.
  - Required: no drive, busy stays 0. A following 18.5 ms pulse is answered normally.
- Checksum wrap: inputs 0xFF,0xFF,0x80,0x02 -> checksum byte 0x80. Bit widths are exactly 1300/3500 cycles.
- Input change mid-frame: change temp_int from 0x19 to 0x55 during bit 10.
  - Required: transmitted temp byte stays 0x19.
- Contention: host pulls low 10 cycles inside the bit-5 BIT_HIGH.
  - Required: err pulse, line released within 2 cycles of detection, state IDLE, no frame_done.
- Reset mid-frame: rst_n=0 during RESP_LOW.
  - Required: line released on that edge, busy=0, no err. Next start is answered normally.
- Host-reader loopback: instantiate with the DHT11 host reader.
  - Required: reader data_rdy asserts; humidity=0x37, temperature=0x19.
